// File: rtl/signed_cmp_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : signed_cmp_rr_scheduler
// Purpose  : Shares one signed less-than / equality comparator among NREQ
//            requesters. A round-robin arbiter grants one operand pair at a
//            time. The pair is compared in one registered stage, and the
//            result is returned with the owner id on a single response
//            channel.
// Ports    : clk, rst_n           - clock (rising edge), async active-low reset
//            req_valid_i [NREQ]   - per-requester operand pair valid
//            req_ready_o [NREQ]   - per-requester accept strobe (one-hot/zero)
//            req_a_i, req_b_i     - packed operands, requester i at [i*WIDTH +: WIDTH]
//            rsp_valid_o/ready_i  - response handshake
//            rsp_id_o, rsp_lt_o, rsp_eq_o - response payload
//            busy_o               - transaction in flight
//            cmp_count_o [16]     - completed-compare counter, wraps
// Revision : 1.0 - initial release
// ============================================================================
module signed_cmp_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*WIDTH-1:0]  req_a_i,
    input  logic [NREQ*WIDTH-1:0]  req_b_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic                   rsp_lt_o,
    output logic                   rsp_eq_o,
    output logic                   busy_o,
    output logic [15:0]            cmp_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_lt_q, rsp_lt_d;
    logic               rsp_eq_q, rsp_eq_d;
    logic [15:0]        cmp_count_q, cmp_count_d;

    logic               w_found;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_cand;
    int                 w_cand_int;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_cand     = '0;
        w_cand_int = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand_int = (int'(rr_ptr_q) + k) % NREQ;
            w_cand     = IDW'(w_cand_int);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_a = req_a_i[i*WIDTH +: WIDTH];
                w_sel_b = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe is combinational in IDLE; forced low while in reset so
    // every output reads zero during reset.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = rst_n && (state_q == ST_IDLE) && w_found
                             && (w_grant == IDW'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gid_d       = gid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_eq_d    = rsp_eq_q;
        cmp_count_d = cmp_count_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    op_a_d  = w_sel_a;
                    op_b_d  = w_sel_b;
                    gid_d   = w_grant;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                rsp_lt_d    = $signed(op_a_q) < $signed(op_b_q);
                rsp_eq_d    = (op_a_q == op_b_q);
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = gid_q;
                    cmp_count_d = cmp_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            gid_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_lt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            cmp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gid_q       <= gid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_eq_q    <= rsp_eq_d;
            cmp_count_q <= cmp_count_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_lt_o    = rsp_lt_q;
    assign rsp_eq_o    = rsp_eq_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign cmp_count_o = cmp_count_q;

endmodule
`default_nettype wire

// File: doc/signed_cmp_rr_scheduler.md
Name: signed_cmp_rr_scheduler

Overview:
Shares a single 32-bit signed less-than comparator among NREQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The scheduler latches the granted pair, evaluates signed(a) < signed(b) and signed(a) == signed(b) in one registered stage, and returns the result with the requester id on one shared response channel. It sits in front of the comparator datapath in the crypto benchmark set, where several producers need ordered compares on one comparator instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand width in bits, two's complement
IDW, 2, id width, equal to clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operand pair valid
req_ready  output  NREQ  per-requester accept strobe, one-hot or zero
req_a  input  NREQ*WIDTH  packed operand a; requester i uses bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  packed operand b, same packing as req_a
rsp_valid  output  1  result valid
rsp_ready  input  1  result consumer ready
rsp_id  output  IDW  index of the requester that owns the result
rsp_lt  output  1  1 when signed(a) < signed(b)
rsp_eq  output  1  1 when a == b
busy  output  1  high when state != IDLE
cmp_count  output  16  completed-compare counter, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_id=0, rsp_lt=0, rsp_eq=0, busy=0, cmp_count=0, rr_ptr=NREQ-1, operand regs=0. Any in-flight transaction is discarded.
- FSM states: IDLE -> CMP -> RSP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
  - req_ready[grant]=1 combinationally, same cycle. Handshake completes in this cycle.
  - Latch req_a and req_b of the grant into op_a and op_b. Latch the grant into gid. Go to CMP.
  - No valid requester: stay in IDLE, req_ready=0.
- CMP:
  - rsp_lt <= signed compare of op_a and op_b; rsp_eq <= (op_a == op_b); rsp_id <= gid; rsp_valid <= 1.
  - Go to RSP. req_ready=0.
- RSP:
  - Hold rsp_valid and the result fields stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, rr_ptr <= gid, cmp_count <= cmp_count+1, go to IDLE.
  - req_ready=0 throughout RSP.
- Latency: handshake in cycle T gives rsp_valid high in cycle T+2. Minimum spacing between grants is 3 cycles; there is no overlap of transactions.
- req_ready is nonzero only in IDLE and has at most one bit set.
- Requesters hold req_valid and operands stable until req_ready. The scheduler never samples operands outside the handshake cycle.
- req_valid dropping while not granted is tolerated and is simply skipped.
- Signed compare rules:
  - Negative < positive.
  - 0x80000000 is the minimum value.
  - Equal operands give lt=0, eq=1.
  - lt and eq are never both 1.
- cmp_count increments only on a completed response handshake. It wraps modulo 2^16.
- Reset asserted in CMP or RSP: outputs clear immediately. After release, arbitration restarts with requester 0 as highest priority.

Test Plan:
- Only req_valid[0], a=0xFFFFFFFF, b=0x00000001, rsp_ready=1 -> req_ready[0]=1 at T; rsp_valid=1 at T+2 with rsp_id=0, lt=1, eq=0; cmp_count=1 after the response.
- Boundary compares: (0x7FFFFFFF, 0x80000000) -> lt=0 eq=0; (0x80000000, 0x7FFFFFFF) -> lt=1; (0x12345678, 0x12345678) -> lt=0 eq=1; (0x00000000, 0xFFFFFFFF) -> lt=0.
- All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,1 with one grant every 3 cycles; rsp_id follows the same order.
- Back-pressure: rsp_ready=0 for 5 cycles in RSP -> rsp_valid, id, lt and eq stay stable; req_ready=0 and busy=1 throughout; one completion when rsp_ready goes to 1.
- rst_n pulsed low during CMP with requester 2 granted, then req_valid=0b1111 -> all outputs 0 during reset; first grant after release is requester 0.
- Preload 65535 completions, then one more compare -> cmp_count goes 0xFFFF -> 0x0000.
